// File: rtl/nyq_out_buffer.sv
// nyq_out_buffer: captures decimated samples from the Nyquist filter, applies
// a saturating Q(GAIN_FRAC) gain and queues the results in a show-ahead FIFO
// drained over a valid/ready handshake.
// Build option: define NYQBUF_GAIN_EN to include the gain multiplier and the
// addr-0 GAIN register; without it samples pass through the stage unchanged.
module nyq_out_buffer #(
    parameter int ADDR_WIDTH = 9,
    parameter int MEM_WIDTH  = 32,
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_FRAC  = 14,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [DATA_WIDTH-1:0] In_DI,
    input  logic                  InValid_SI,
    output logic [DATA_WIDTH-1:0] Out_DO,
    output logic                  OutValid_SO,
    input  logic                  OutReady_SI,
    output logic [DEPTH_LOG2:0]   Level_DO,
    output logic                  Ovf_SO
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = DEPTH[DEPTH_LOG2:0];

    logic                  flush;
    logic [DATA_WIDTH-1:0] stage_next;
    logic [DATA_WIDTH-1:0] stage_data;
    logic                  stage_valid;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  ovf;
    logic                  full;
    logic                  pop;
    logic                  push;

    assign flush = WrEn_SI && (Addr_DI == ADDR_WIDTH'(1)) && PAR_In_DI[0];

`ifdef NYQBUF_GAIN_EN
    localparam int PW = DATA_WIDTH + GAIN_WIDTH;
    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = GAIN_WIDTH'(1 << GAIN_FRAC);

    logic [GAIN_WIDTH-1:0] gain;
    logic [PW-1:0]         product;
    logic [PW-1:0]         shifted;
    logic [PW-DATA_WIDTH:0] head_bits;
    logic                  unused_par;

    assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:GAIN_WIDTH];

    // Product of sign-extended operands equals the exact signed product mod 2^PW
    always_comb begin
        product = {{GAIN_WIDTH{In_DI[DATA_WIDTH-1]}}, In_DI}
                * {{DATA_WIDTH{gain[GAIN_WIDTH-1]}}, gain};
        shifted   = $signed(product) >>> GAIN_FRAC;
        head_bits = shifted[PW-1:DATA_WIDTH-1];
        if ((head_bits == '0) || (head_bits == '1)) begin
            stage_next = shifted[DATA_WIDTH-1:0];
        end else if (shifted[PW-1]) begin
            stage_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            stage_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // GAIN register; survives flush, restored to unity on reset
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            gain <= GAIN_UNITY;
        end else if (WrEn_SI && (Addr_DI == '0)) begin
            gain <= PAR_In_DI[GAIN_WIDTH-1:0];
        end
    end
`else
    logic unused_par;

    assign unused_par = ^{PAR_In_DI[MEM_WIDTH-1:1], GAIN_WIDTH[0], GAIN_FRAC[0]};

    // Pass-through stage input
    always_comb begin
        stage_next = In_DI;
    end
`endif

    // Single-register scaling stage; flush drops both the held and incoming sample
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (flush) begin
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= InValid_SI;
            if (InValid_SI) begin
                stage_data <= stage_next;
            end
        end
    end

    assign full = (level == LEVEL_FULL);
    assign pop  = (level != '0) && OutReady_SI;
    // A pop frees the slot the push uses, so full+push+pop still accepts
    assign push = stage_valid && (!full || pop);

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= stage_data;
                wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
            if (stage_valid && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign Out_DO      = mem[rd_ptr];
    assign OutValid_SO = (level != '0);
    assign Level_DO    = level;
    assign Ovf_SO      = ovf;

endmodule

// File: tb/tb_nyq_out_buffer.sv
// Directed bench for nyq_out_buffer: latency, gain/saturation, overflow,
// flush, full push+pop and asynchronous reset.
module tb_nyq_out_buffer;

`ifdef NYQBUF_GAIN_EN
    localparam bit GAIN_ON = 1'b1;
`else
    localparam bit GAIN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [8:0]  addr;
    logic [31:0] par;
    logic [23:0] in_data;
    logic        in_valid;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        ovf;

    int tests;
    int failed;

    nyq_out_buffer dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .WrEn_SI     (wr_en),
        .Addr_DI     (addr),
        .PAR_In_DI   (par),
        .In_DI       (in_data),
        .InValid_SI  (in_valid),
        .Out_DO      (out_data),
        .OutValid_SO (out_valid),
        .OutReady_SI (out_ready),
        .Level_DO    (level),
        .Ovf_SO      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [8:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        par   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push(input logic [23:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (out_data !== 24'h0) begin failed++; $display("FAIL reset_out got %h expected %h", out_data, 24'h0); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b expected 0", out_valid); end
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL reset_level got %0d expected 0", level); end
        tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL reset_ovf got %b expected 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        push(24'h000100);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_valid_early got %b expected 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid got %b expected 1", out_valid); end
        tests++; if (out_data !== 24'h000100) begin failed++; $display("FAIL basic_out got %h expected %h", out_data, 24'h000100); end
        tests++; if (level !== 4'd1) begin failed++; $display("FAIL basic_level got %0d expected 1", level); end
        out_ready = 1'b1;
        tick();
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL basic_pop_level got %0d expected 0", level); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_pop_valid got %b expected 0", out_valid); end
        tick();
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL ready_empty_level got %0d expected 0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_empty_ready();
        out_ready = 1'b1;
        push(24'h000123);
        tick();
        tests++; if (level !== 4'd1) begin failed++; $display("FAIL empty_ready_level got %0d expected 1", level); end
        tests++; if (out_data !== 24'h000123) begin failed++; $display("FAIL empty_ready_out got %h expected %h", out_data, 24'h000123); end
        tick();
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL empty_ready_drain got %0d expected 0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_gain();
        logic [23:0] exp_q [5];
        exp_q[0] = 24'h7FFFFF;
        exp_q[1] = 24'h800000;
        exp_q[2] = 24'hFFFFFF;
        exp_q[3] = GAIN_ON ? 24'h000080 : 24'h000100;
        exp_q[4] = GAIN_ON ? 24'hFFFE00 : 24'h000100;
        out_ready = 1'b0;
        write_reg(9'd0, 32'h7FFF);
        push(24'h7FFFFF);
        push(24'h800000);
        write_reg(9'd0, 32'h2000);
        push(24'hFFFFFF);
        // gain write and sample in the same cycle: sample still sees 0x2000
        wr_en = 1'b1; addr = 9'd0; par = 32'h8000;
        in_data = 24'h000100; in_valid = 1'b1;
        tick();
        wr_en = 1'b0;
        push(24'h000100);
        tick();
        tests++; if (level !== 4'd5) begin failed++; $display("FAIL gain_level got %0d expected 5", level); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++; if (out_data !== exp_q[i]) begin failed++; $display("FAIL gain_out[%0d] got %h expected %h", i, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL gain_drain got %0d expected 0", level); end
    endtask

    task automatic test_overflow();
        write_reg(9'd0, 32'h4000);
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in_data = 24'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tests++; if (level !== 4'd8) begin failed++; $display("FAIL ovf_level got %0d expected 8", level); end
        tests++; if (ovf !== 1'b1) begin failed++; $display("FAIL ovf_flag got %b expected 1", ovf); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tests++; if (out_data !== 24'(i)) begin failed++; $display("FAIL ovf_out[%0d] got %h expected %h", i, out_data, 24'(i)); end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (level !== 4'd0 || out_valid !== 1'b0) begin failed++; $display("FAIL ovf_drain got level %0d valid %b expected 0 0", level, out_valid); end
        tests++; if (ovf !== 1'b1) begin failed++; $display("FAIL ovf_sticky got %b expected 1", ovf); end
    endtask

    task automatic test_flush();
        write_reg(9'd0, 32'h2000);
        for (int i = 0; i < 5; i++) push(24'h000010 + 24'(i));
        tick();
        tests++; if (level !== 4'd5) begin failed++; $display("FAIL flush_pre_level got %0d expected 5", level); end
        tests++; if (ovf !== 1'b1) begin failed++; $display("FAIL flush_pre_ovf got %b expected 1", ovf); end
        wr_en = 1'b1; addr = 9'd1; par = 32'h1;
        in_data = 24'h000777; in_valid = 1'b1;
        tick();
        wr_en = 1'b0; in_valid = 1'b0;
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL flush_level got %0d expected 0", level); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL flush_valid got %b expected 0", out_valid); end
        tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL flush_ovf got %b expected 0", ovf); end
        tick();
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL flush_discard got %0d expected 0", level); end
        push(24'h000100);
        tick();
        tests++; if (level !== 4'd1) begin failed++; $display("FAIL flush_post_level got %0d expected 1", level); end
        tests++; if (out_data !== (GAIN_ON ? 24'h000080 : 24'h000100)) begin failed++; $display("FAIL flush_gain_kept got %h expected %h", out_data, GAIN_ON ? 24'h000080 : 24'h000100); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [23:0] exp_q [8];
        write_reg(9'd0, 32'h4000);
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(24'(i));
        tick();
        tests++; if (level !== 4'd8) begin failed++; $display("FAIL full_level got %0d expected 8", level); end
        push(24'h000055);
        // stage holds 0x55; next edge pushes it while popping the head
        out_ready = 1'b1;
        tick();
        tests++; if (level !== 4'd8) begin failed++; $display("FAIL full_pp_level got %0d expected 8", level); end
        tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL full_pp_ovf got %b expected 0", ovf); end
        for (int i = 0; i < 7; i++) exp_q[i] = 24'(i + 2);
        exp_q[7] = 24'h000055;
        for (int i = 0; i < 8; i++) begin
            tests++; if (out_data !== exp_q[i]) begin failed++; $display("FAIL full_pp_out[%0d] got %h expected %h", i, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL full_pp_drain got %0d expected 0", level); end
    endtask

    task automatic test_reset_midstream();
        write_reg(9'd0, 32'h2000);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(24'h000AA0 + 24'(i));
        tick();
        tests++; if (level !== 4'd4) begin failed++; $display("FAIL rst_mid_pre got %0d expected 4", level); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_data !== 24'h0) begin failed++; $display("FAIL rst_mid_out got %h expected %h", out_data, 24'h0); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_mid_valid got %b expected 0", out_valid); end
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL rst_mid_level got %0d expected 0", level); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_mid_stale got %b expected 0", out_valid); end
        push(24'h000100);
        tick();
        tests++; if (out_data !== 24'h000100) begin failed++; $display("FAIL rst_mid_gain got %h expected %h", out_data, 24'h000100); end
        tests++; if (level !== 4'd1) begin failed++; $display("FAIL rst_mid_post_level got %0d expected 1", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (level !== 4'd0) begin failed++; $display("FAIL rst_mid_drain got %0d expected 0", level); end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        addr      = '0;
        par       = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_empty_ready();
        test_gain();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
